pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter unit for the processor's fetch stage. It generalises the fixed PC register plus PC+4 adder. The increment step, width and reset vector are configurable. It adds stall, relative branch, absolute jump, and call/return support through an internal return-address stack (RAS). It drives the fetch address every cycle and receives redirect commands from the decode/execute stages.

## Interface
- WIDTH, 32, PC and address width in bits (≥ 8)
- STEP, 4, sequential increment added to PC each non-stalled cycle
- RESET_VECTOR, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥ 2)

- clock  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high
- stall  in  1  1 = hold PC and RAS unchanged this cycle
- op  in  3  000 SEQ, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET; 101–111 treated as SEQ
- taken  in  1  qualifies BRANCH only; 0 = behave as SEQ
- offset  in  WIDTH  two's-complement branch displacement, relative to current pc
- target  in  WIDTH  absolute destination for JUMP/CALL
- pc  out  WIDTH  registered current fetch address
- pc_plus  out  WIDTH  combinational pc + STEP (mod 2^WIDTH)
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_empty  out  1  ras_count == 0
- ras_full  out  1  ras_count == RAS_DEPTH
- ras_err  out  1  sticky; set on CALL while full or RET while empty

## Operation
- Reset (clock edge with reset=1): pc ← RESET_VECTOR, ras_count ← 0, ras_err ← 0. Stack contents are don't-care. Reset overrides stall and op.
- stall=1 (reset=0): pc, RAS contents, ras_count and ras_err hold. op is ignored entirely. No push or pop occurs.
- With stall=0, the next pc is selected by op:
  - SEQ: pc ← pc + STEP.
  - BRANCH, taken=1: pc ← pc + offset. taken=0: pc ← pc + STEP.
  - JUMP: pc ← target.
  - CALL, not full: push pc + STEP, then pc ← target, ras_count+1.
  - CALL, full: the push is discarded and ras_count is unchanged. pc ← target still applies. ras_err ← 1.
  - RET, not empty: pc ← top entry (most recent push), ras_count−1.
  - RET, empty: pc ← pc + STEP and ras_err ← 1.
- RAS is strictly LIFO. The stack pointer never wraps, and overflow never corrupts existing entries.
- All arithmetic is unsigned modulo 2^WIDTH. Address wrap-around is legal and silent, e.g. pc = 2^WIDTH−4 with STEP=4 gives 0.
- No alignment check is made on target or offset.
- ras_err clears only on reset.

## Timing
- Single-cycle redirect: a command sampled at edge N is reflected on pc after edge N.
- pc, ras_count and ras_err are registers; every other output is combinational from them.
- pc_plus, ras_empty and ras_full follow pc and ras_count within the same cycle.
- The RAS read (top entry) is combinational. A RET immediately after a CALL returns the value pushed by that CALL.
- A reset asserted mid-sequence (e.g. during a CALL cycle) wins: no push occurs, and the state equals the reset values after that edge.
- Reset values: pc = RESET_VECTOR, pc_plus = RESET_VECTOR + STEP, ras_count = 0, ras_empty = 1, ras_full = 0, ras_err = 0.

## Test plan
- Reset then 3 SEQ cycles (WIDTH=32, STEP=4, RESET_VECTOR=0x100) -> pc = 0x100, 0x104, 0x108, 0x10C; pc_plus always pc+4.
- BRANCH taken=1 with offset=−8 at pc=0x10C -> pc = 0x104. BRANCH taken=0 -> pc = 0x110. JUMP target=0x2000 -> pc = 0x2000.
- Stall asserted for 3 cycles with op=CALL during the stall -> pc, ras_count and ras_err unchanged. First non-stalled CALL pushes exactly once.
- Nested CALLs at pc 0x10, 0x40, 0x80 (targets 0x40, 0x80, 0xC0), then 3 RETs -> pc = 0x84, 0x44, 0x14. ras_count goes 1, 2, 3, 2, 1, 0; ras_empty = 1 at end.
- RAS_DEPTH=4, 5 CALLs -> 5th CALL redirects to its target, ras_count stays 4, ras_err = 1. Following 4 RETs return the first four pushes in LIFO order. A 5th RET gives pc+4 with ras_err still 1.
- pc = 0xFFFFFFFC then SEQ -> pc = 0. Reset asserted together with a CALL while stall=1 -> pc = RESET_VECTOR, ras_count = 0, ras_err = 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential step, relative branch, absolute jump,
// and call/return through a small return-address stack (RAS).
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4,
  localparam int              CW           = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       op,
  input  logic             taken,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [CW-1:0]    ras_count,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int               PW     = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [WIDTH-1:0] pc_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             err_nxt;
  logic             push;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    push_idx;
  logic [WIDTH-1:0] ras_top;

  assign pc_plus   = pc + STEP_W;
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));
  // Pointer is a count, not a wrapping index: a full stack never overwrites.
  assign top_idx   = PW'(ras_count - CW'(1));
  assign push_idx  = PW'(ras_count);
  assign ras_top   = ras_mem[top_idx];

  always_comb begin
    pc_nxt  = pc_plus;
    cnt_nxt = ras_count;
    err_nxt = ras_err;
    push    = 1'b0;
    case (op)
      OP_BRANCH: if (taken) pc_nxt = pc + offset;
      OP_JUMP:   pc_nxt = target;
      OP_CALL: begin
        pc_nxt = target;
        if (ras_full) begin
          err_nxt = 1'b1;
        end else begin
          push    = 1'b1;
          cnt_nxt = ras_count + CW'(1);
        end
      end
      OP_RET: begin
        if (ras_empty) begin
          err_nxt = 1'b1;
        end else begin
          pc_nxt  = ras_top;
          cnt_nxt = ras_count - CW'(1);
        end
      end
      OP_SEQ:  pc_nxt = pc_plus;
      default: pc_nxt = pc_plus;
    endcase
  end

  // Control state: pc, stack depth and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      ras_count <= '0;
      ras_err   <= 1'b0;
    end else if (!stall) begin
      pc        <= pc_nxt;
      ras_count <= cnt_nxt;
      ras_err   <= err_nxt;
    end
  end

  // Stack contents carry no reset; a reset cycle only blocks the write.
  always_ff @(posedge clock) begin
    if (!reset && !stall && push) ras_mem[push_idx] <= pc_plus;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scripted command rows with a scoreboard
// of expected pc / stack depth / error state per clock edge.
module tb_pc_sequencer;

  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] RV    = 32'h100;
  localparam logic [2:0]  SEQ = 3'd0, BR = 3'd1, JMP = 3'd2, CALL = 3'd3, RET = 3'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        taken = 1'b0;
  logic [31:0] offset = '0;
  logic [31:0] target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [CW-1:0] ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [2:0]  op;
    logic        tk;
    logic [31:0] off;
    logic [31:0] tgt;
    logic [31:0] epc;
    int          ecnt;
    logic        eerr;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    int          cnt;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  pc_sequencer #(
    .WIDTH(32), .STEP(4), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall), .op(op), .taken(taken),
    .offset(offset), .target(target), .pc(pc), .pc_plus(pc_plus),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_err(ras_err)
  );

  always #5 clock = ~clock;

  function automatic row_t mk(input logic rst, input logic stl, input logic [2:0] o,
                              input logic tk, input logic [31:0] off, input logic [31:0] tgt,
                              input logic [31:0] epc, input int ecnt, input logic eerr);
    row_t r;
    r.rst = rst; r.stl = stl; r.op = o; r.tk = tk; r.off = off; r.tgt = tgt;
    r.epc = epc; r.ecnt = ecnt; r.eerr = eerr;
    return r;
  endfunction

  // Drive one command row, record its expectation, and advance past the edge.
  task automatic step(input row_t r);
    exp_t e;
    @(negedge clock);
    reset = r.rst; stall = r.stl; op = r.op; taken = r.tk; offset = r.off; target = r.tgt;
    e.pc = r.epc; e.cnt = r.ecnt; e.err = r.eerr;
    sbq.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, SEQ, 0, 0, 0, RV, 0, 0));
    foreach (rows[i]) begin
      step(rows[i]);
      e = sbq.pop_front();
      checks++; if (pc !== e.pc) begin failures++; $display("FAIL reset[%0d] pc got=%h exp=%h", i, pc, e.pc); end
      checks++; if (pc_plus !== e.pc + 32'd4) begin failures++; $display("FAIL reset[%0d] pc_plus got=%h exp=%h", i, pc_plus, e.pc + 32'd4); end
      checks++; if (ras_count !== CW'(e.cnt)) begin failures++; $display("FAIL reset[%0d] ras_count got=%0d exp=%0d", i, ras_count, e.cnt); end
      checks++; if (ras_empty !== (e.cnt == 0)) begin failures++; $display("FAIL reset[%0d] ras_empty got=%b", i, ras_empty); end
      checks++; if (ras_full !== (e.cnt == DEPTH)) begin failures++; $display("FAIL reset[%0d] ras_full got=%b", i, ras_full); end
      checks++; if (ras_err !== e.err) begin failures++; $display("FAIL reset[%0d] ras_err got=%b exp=%b", i, ras_err, e.err); end
    end
  endtask

  task automatic test_seq_branch_jump();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 0, SEQ,    0, 0,            0,            32'h104,  0, 0));
    rows.push_back(mk(0, 0, SEQ,    0, 0,            0,            32'h108,  0, 0));
    rows.push_back(mk(0, 0, SEQ,    0, 0,            0,            32'h10C,  0, 0));
    rows.push_back(mk(0, 0, BR,     1, 32'hFFFFFFF8, 0,            32'h104,  0, 0));
    rows.push_back(mk(0, 0, JMP,    0, 0,            32'h10C,      32'h10C,  0, 0));
    rows.push_back(mk(0, 0, BR,     0, 32'hFFFFFFF8, 0,            32'h110,  0, 0));
    rows.push_back(mk(0, 0, 3'b111, 1, 32'h40,       32'h9000,     32'h114,  0, 0));
    rows.push_back(mk(0, 0, 3'b101, 1, 32'h40,       32'h9000,     32'h118,  0, 0));
    rows.push_back(mk(0, 0, JMP,    0, 0,            32'h2000,     32'h2000, 0, 0));
    foreach (rows[i]) begin
      step(rows[i]);
      e = sbq.pop_front();
      checks++; if (pc !== e.pc) begin failures++; $display("FAIL seq_br_jmp[%0d] pc got=%h exp=%h", i, pc, e.pc); end
      checks++; if (pc_plus !== e.pc + 32'd4) begin failures++; $display("FAIL seq_br_jmp[%0d] pc_plus got=%h exp=%h", i, pc_plus, e.pc + 32'd4); end
      checks++; if (ras_count !== CW'(e.cnt)) begin failures++; $display("FAIL seq_br_jmp[%0d] ras_count got=%0d exp=%0d", i, ras_count, e.cnt); end
      checks++; if (ras_err !== e.err) begin failures++; $display("FAIL seq_br_jmp[%0d] ras_err got=%b exp=%b", i, ras_err, e.err); end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 1, CALL, 0, 0, 32'h3000, 32'h2000, 0, 0));
    rows.push_back(mk(0, 1, CALL, 0, 0, 32'h3000, 32'h2000, 0, 0));
    rows.push_back(mk(0, 1, RET,  0, 0, 32'h3000, 32'h2000, 0, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'h3000, 32'h3000, 1, 0));
    rows.push_back(mk(0, 1, JMP,  0, 0, 32'h7000, 32'h3000, 1, 0));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,        32'h2004, 0, 0));
    foreach (rows[i]) begin
      step(rows[i]);
      e = sbq.pop_front();
      checks++; if (pc !== e.pc) begin failures++; $display("FAIL stall[%0d] pc got=%h exp=%h", i, pc, e.pc); end
      checks++; if (ras_count !== CW'(e.cnt)) begin failures++; $display("FAIL stall[%0d] ras_count got=%0d exp=%0d", i, ras_count, e.cnt); end
      checks++; if (ras_empty !== (e.cnt == 0)) begin failures++; $display("FAIL stall[%0d] ras_empty got=%b", i, ras_empty); end
      checks++; if (ras_err !== e.err) begin failures++; $display("FAIL stall[%0d] ras_err got=%b exp=%b", i, ras_err, e.err); end
    end
  endtask

  task automatic test_nested();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 0, JMP,  0, 0, 32'h10, 32'h10, 0, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'h40, 32'h40, 1, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'h80, 32'h80, 2, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'hC0, 32'hC0, 3, 0));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,      32'h84, 2, 0));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,      32'h44, 1, 0));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,      32'h14, 0, 0));
    foreach (rows[i]) begin
      step(rows[i]);
      e = sbq.pop_front();
      checks++; if (pc !== e.pc) begin failures++; $display("FAIL nested[%0d] pc got=%h exp=%h", i, pc, e.pc); end
      checks++; if (ras_count !== CW'(e.cnt)) begin failures++; $display("FAIL nested[%0d] ras_count got=%0d exp=%0d", i, ras_count, e.cnt); end
      checks++; if (ras_empty !== (e.cnt == 0)) begin failures++; $display("FAIL nested[%0d] ras_empty got=%b", i, ras_empty); end
      checks++; if (ras_full !== (e.cnt == DEPTH)) begin failures++; $display("FAIL nested[%0d] ras_full got=%b", i, ras_full); end
      checks++; if (ras_err !== e.err) begin failures++; $display("FAIL nested[%0d] ras_err got=%b exp=%b", i, ras_err, e.err); end
    end
  endtask

  task automatic test_overflow();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 0, JMP,  0, 0, 32'h500, 32'h500, 0, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'h600, 32'h600, 1, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'h700, 32'h700, 2, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'h800, 32'h800, 3, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'h900, 32'h900, 4, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'hA00, 32'hA00, 4, 1));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,       32'h804, 3, 1));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,       32'h704, 2, 1));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,       32'h604, 1, 1));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,       32'h504, 0, 1));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,       32'h508, 0, 1));
    foreach (rows[i]) begin
      step(rows[i]);
      e = sbq.pop_front();
      checks++; if (pc !== e.pc) begin failures++; $display("FAIL overflow[%0d] pc got=%h exp=%h", i, pc, e.pc); end
      checks++; if (ras_count !== CW'(e.cnt)) begin failures++; $display("FAIL overflow[%0d] ras_count got=%0d exp=%0d", i, ras_count, e.cnt); end
      checks++; if (ras_empty !== (e.cnt == 0)) begin failures++; $display("FAIL overflow[%0d] ras_empty got=%b", i, ras_empty); end
      checks++; if (ras_full !== (e.cnt == DEPTH)) begin failures++; $display("FAIL overflow[%0d] ras_full got=%b", i, ras_full); end
      checks++; if (ras_err !== e.err) begin failures++; $display("FAIL overflow[%0d] ras_err got=%b exp=%b", i, ras_err, e.err); end
    end
  endtask

  task automatic test_wrap_and_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 0, SEQ,  0, 0, 0,            RV,           0, 0));
    rows.push_back(mk(0, 0, JMP,  0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0));
    rows.push_back(mk(0, 0, SEQ,  0, 0, 0,            32'h0,        0, 0));
    rows.push_back(mk(0, 0, CALL, 0, 0, 32'h40,       32'h40,       1, 0));
    rows.push_back(mk(1, 1, CALL, 0, 0, 32'h80,       RV,           0, 0));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,            32'h104,      0, 1));
    rows.push_back(mk(1, 0, CALL, 0, 0, 32'h80,       RV,           0, 0));
    rows.push_back(mk(0, 0, RET,  0, 0, 0,            32'h104,      0, 1));
    foreach (rows[i]) begin
      step(rows[i]);
      e = sbq.pop_front();
      checks++; if (pc !== e.pc) begin failures++; $display("FAIL wrap_reset[%0d] pc got=%h exp=%h", i, pc, e.pc); end
      checks++; if (pc_plus !== e.pc + 32'd4) begin failures++; $display("FAIL wrap_reset[%0d] pc_plus got=%h exp=%h", i, pc_plus, e.pc + 32'd4); end
      checks++; if (ras_count !== CW'(e.cnt)) begin failures++; $display("FAIL wrap_reset[%0d] ras_count got=%0d exp=%0d", i, ras_count, e.cnt); end
      checks++; if (ras_err !== e.err) begin failures++; $display("FAIL wrap_reset[%0d] ras_err got=%b exp=%b", i, ras_err, e.err); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq_branch_jump();
    test_stall();
    test_nested();
    test_overflow();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
